// File: rtl/store_merge_buffer.sv
// Store merge buffer: places stores onto byte lanes, queues them, coalesces
// same-word stores into the youngest entry, drains the head entry to data
// memory and forwards queued bytes to loads.
module store_merge_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     StValid,
  output logic                     StReady,
  input  logic [AW-1:0]            StAddr,
  input  logic [1:0]               StType,
  input  logic [XLEN-1:0]          StWD,
  output logic                     StMisalign,
  output logic                     MemValid,
  input  logic                     MemReady,
  output logic [AW-1:0]            MemAddr,
  output logic [XLEN-1:0]          MemWD,
  output logic [XLEN/8-1:0]        MemBE,
  input  logic [AW-1:0]            LdAddr,
  output logic [XLEN/8-1:0]        FwdMask,
  output logic [XLEN-1:0]          FwdData,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(NB - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. StReady depends on StAddr/StType (coalesce hit) but never on
  // MemReady; MemValid and the Mem* payload depend only on registered state
  // and stay stable while MemValid=1 and MemReady=0.

  logic [AW-1:0]   r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [NB-1:0]   r_be   [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_misalign;

  logic [OW-1:0]   w_off;
  logic            w_legal;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_st_data;
  logic [XLEN-1:0] w_new_data;
  logic [AW-1:0]   w_st_aligned;
  logic [AW-1:0]   w_ld_aligned;
  logic [PW-1:0]   w_young;
  logic            w_hit;
  logic            w_accept;
  logic            w_push;
  logic            w_merge;
  logic            w_drain;
  logic [NB-1:0]   w_fwd_mask;
  logic [XLEN-1:0] w_fwd_data;

  assign w_off        = StAddr[OW-1:0];
  assign w_st_aligned = StAddr & ALIGN_MASK;
  assign w_ld_aligned = LdAddr & ALIGN_MASK;
  assign w_st_data    = StWD << {w_off, 3'b000};
  assign w_new_data   = w_st_data & w_lane;
  assign w_young      = r_tail - PW'(1);

  // Decode store size into byte-enables and check natural alignment.
  always_comb begin
    w_legal = 1'b0;
    w_be    = '0;
    case (StType)
      2'b00: begin
        w_legal = 1'b1;
        w_be    = NB'(1) << w_off;
      end
      2'b01: begin
        w_legal = ~w_off[0];
        w_be    = NB'(3) << w_off;
      end
      2'b10: begin
        w_legal = (w_off[1:0] == 2'b00);
        w_be    = NB'(15) << w_off;
      end
      default: begin
        w_legal = (XLEN == 64) && (w_off == '0);
        w_be    = '1;
      end
    endcase
  end

  // Expand byte-enables into a bit mask over the data word.
  always_comb begin
    w_lane = '0;
    for (int b = 0; b < NB; b++) begin
      w_lane[b*8 +: 8] = {8{w_be[b]}};
    end
  end

  // The head entry may be in flight, so coalescing needs at least two entries.
  assign w_hit    = (r_count >= CW'(2)) && (r_addr[w_young] == w_st_aligned) && w_legal;
  assign StReady  = (r_count < CW'(DEPTH)) || w_hit;
  assign w_accept = StValid && StReady;
  assign w_push   = w_accept && w_legal && !w_hit;
  assign w_merge  = w_accept && w_hit;

  assign MemValid = (r_count != '0);
  assign w_drain  = MemValid && MemReady;
  assign MemAddr  = r_addr[r_head];
  assign MemWD    = r_data[r_head];
  assign MemBE    = r_be[r_head];

  assign StMisalign = r_misalign;
  assign Count      = r_count;

  // Pointer, occupancy and misalign-pulse bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept && !w_legal;
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: new entries at the tail, coalesced bytes into the youngest.
  // Lanes outside the byte-enables of a fresh entry hold zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= w_st_aligned;
      r_be[r_tail]   <= w_be;
      r_data[r_tail] <= w_new_data;
    end
    if (w_merge) begin
      r_be[w_young]   <= r_be[w_young] | w_be;
      r_data[w_young] <= (r_data[w_young] & ~w_lane) | w_new_data;
    end
  end

  // Load forwarding: scan oldest to youngest so younger bytes overwrite older.
  always_comb begin
    w_fwd_mask = '0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_addr[r_head + PW'(i)] == w_ld_aligned)) begin
        for (int b = 0; b < NB; b++) begin
          if (r_be[r_head + PW'(i)][b]) begin
            w_fwd_mask[b]        = 1'b1;
            w_fwd_data[b*8 +: 8] = r_data[r_head + PW'(i)][b*8 +: 8];
          end
        end
      end
    end
  end

  assign FwdMask = w_fwd_mask;
  assign FwdData = w_fwd_data;

endmodule

// File: doc/store_merge_buffer.md
Name: store_merge_buffer

Overview:
- Parametrised successor to the combinational store-lane merger.
- Sits between the pipeline MEM stage and data memory.
- Places byte, half, word and double stores onto byte lanes with byte-enables, so data memory needs no read-modify-write.
- Queues stores in a FIFO, coalesces a store into the youngest queued entry when both target the same aligned word, drains entries over a valid/ready handshake, and forwards queued bytes to loads.

Parameters:
XLEN, 32, data width in bits; 32 or 64 only; NB = XLEN/8 byte lanes, OW = log2(NB).
DEPTH, 4, number of buffer entries; power of two, at least 2.
AW, 32, address width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
StValid  in  1  store request valid.
StReady  out  1  store request can be accepted this cycle.
StAddr  in  AW  byte address of the store.
StType  in  2  store size: 00 byte, 01 half, 10 word, 11 double.
StWD  in  XLEN  store data, right-aligned.
StMisalign  out  1  one-cycle pulse: the previous accepted store was dropped.
MemValid  out  1  head entry is presented to memory.
MemReady  in  1  memory accepts the head entry.
MemAddr  out  AW  aligned address of the head entry; low OW bits are 0.
MemWD  out  XLEN  lane-placed data of the head entry.
MemBE  out  NB  byte-enables of the head entry.
LdAddr  in  AW  load address for forwarding.
FwdMask  out  NB  lanes of the aligned word at LdAddr that are held in the buffer.
FwdData  out  XLEN  forwarded bytes; lanes not set in FwdMask read 0.
Count  out  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all entries invalid, head and tail pointers 0, Count=0.
  - MemValid=0, StMisalign=0, StReady=1.
  - Mid-operation reset discards queued stores without draining them.
- Lane placement:
  - offset o = StAddr[OW-1:0].
  - Byte: BE = 1<<o; data byte 0 goes to lane o.
  - Half: BE = 2'b11<<o; data bytes 0–1 go to lanes o..o+1.
  - Word: BE = 4'hF<<o, data bytes 0–3.
  - Double: BE = all lanes.
- Illegal or misaligned stores: half with o[0]=1; word with o[1:0]!=0; double with o!=0; any double when XLEN=32.
  - The store is still handshaken (consumes StValid&StReady) but is not written.
  - StMisalign=1 in the following cycle only.
- Acceptance occurs on StValid & StReady. StReady = (Count < DEPTH) OR coalesce hit.
  - StReady does not look ahead to a drain in the same cycle.
- Coalesce hit requires all of:
  - Count >= 2;
  - youngest entry address equals StAddr with its low OW bits cleared;
  - the store is legal.
  - Coalesce is never allowed into the head entry, because it may be in flight.
- On a coalesce: the youngest entry's BE |= new BE, and each newly enabled lane's data is overwritten. Count is unchanged.
- On a non-coalesce legal accept: write the entry at tail, tail+1 modulo DEPTH, Count+1.
- Drain:
  - MemValid = (Count != 0). MemAddr, MemWD and MemBE come from the head entry, registered, with no combinational path from St* inputs.
  - MemValid&MemReady: head+1 modulo DEPTH, Count-1.
  - MemAddr, MemWD and MemBE stay stable while MemValid=1 and MemReady=0.
- Simultaneous accept and drain: Count unchanged; both pointers advance.
  - When full (Count=DEPTH), a non-coalescing store is stalled that cycle even if a drain occurs.
- Latency: a store accepted at edge N into an empty buffer gives MemValid=1 after edge N (visible in cycle N+1).
- Forwarding (combinational):
  - Scan valid entries from oldest to youngest whose address equals the aligned LdAddr.
  - For each lane, the youngest matching entry with that BE bit set supplies the byte.
  - FwdMask is the OR of the matching BEs.
  - The entry being drained in the current cycle still forwards.
- Pointer wrap-around: DEPTH is a power of two, so pointers wrap naturally. Count distinguishes full from empty.

Test Plan:
- Reset, then one store: XLEN=32, SW 0x1000 data 0xDEADBEEF, MemReady=1 → the next cycle shows MemValid=1, MemAddr=0x1000, MemBE=4'hF, MemWD=0xDEADBEEF, followed by Count=0.
- Byte lanes, MemReady=0: SB 0x2003 data 0xAB → entry BE=4'b1000, WD[31:24]=0xAB. SH 0x2002 data 0x1234 → BE=4'b1100, WD[31:16]=0x1234.
- Coalescing: MemReady=0, SW 0x3000 0x11111111, SB 0x4001 0x22, SB 0x4002 0x33 → Count=2. Entry 1 has BE=4'b0110 and data 0x00332200. FwdMask for LdAddr=0x4000 is 4'b0110.
- Misaligned and illegal: SH 0x5001 → StReady=1, no entry written, StMisalign pulses for one cycle. SD with XLEN=32 → same response.
- Full and wrap-around, DEPTH=4, MemReady=0:
  - 4 stores to distinct words → StReady=0 for a 5th distinct address; StReady=1 for a 5th store to the 4th word's address (coalesce).
  - Raise MemReady → entries drain in order. A further 4 stores then wrap the pointers with the order preserved.
- Forward priority and reset: SW 0x6000 0xAAAAAAAA, then SB 0x6000 0xBB, with a different address between them to prevent coalesce → FwdData=0xAAAAAABB, FwdMask=4'hF. Then rst_n=0 for one edge → Count=0, MemValid=0, FwdMask=0.
